// File: rtl/cpu_pipeline.sv
// cpu_pipeline: 3-stage ID/EX/WB integer pipeline with a RUN/DRAIN/HALT control FSM.
// Define CPU_PIPELINE_FORWARD_EN to forward EX results into ID; otherwise RAW hazards stall one cycle.
module cpu_pipeline #(
    parameter int          DATA_W   = 32,
    parameter int          NREGS    = 32,
    parameter logic [31:0] PC_RESET = 32'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic [31:0]              pc,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     halted
);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(DATA_W);
    localparam logic [5:0] OP_ADDI = 6'd7;
    localparam logic [5:0] OP_HALT = 6'd63;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] rf [NREGS];
    logic              id_valid;
    logic [31:0]       id_instr;
    logic              ex_valid, ex_we;
    logic [5:0]        ex_op;
    logic [RW-1:0]     ex_rd;
    logic [DATA_W-1:0] ex_a, ex_b, ex_res;
    logic [5:0]        id_op;
    logic [RW-1:0]     id_rs1, id_rs2, id_rd;
    logic              id_use1, id_use2, id_we;
    logic [DATA_W-1:0] op_a, op_b;
    logic              hz1, hz2, stall, accept, drained;

    // ADDI writes the rs2 field; the rd field overlaps its immediate
    assign id_op   = id_instr[31:26];
    assign id_rs1  = id_instr[21 +: RW];
    assign id_rs2  = id_instr[16 +: RW];
    assign id_rd   = (id_op == OP_ADDI) ? id_rs2 : id_instr[11 +: RW];
    assign id_use1 = id_op >= 6'd1 && id_op <= 6'd8;
    assign id_use2 = id_use1 && id_op != OP_ADDI;
    assign id_we   = id_use1 && id_rd != '0;

    assign hz1 = id_valid && ex_we && id_use1 && id_rs1 == ex_rd;
    assign hz2 = id_valid && ex_we && id_use2 && id_rs2 == ex_rd;

`ifdef CPU_PIPELINE_FORWARD_EN
    assign op_a  = hz1 ? ex_res : rf[id_rs1];
    assign op_b  = hz2 ? ex_res : rf[id_rs2];
    assign stall = 1'b0;
`else
    assign op_a  = rf[id_rs1];
    assign op_b  = rf[id_rs2];
    assign stall = hz1 || hz2;
`endif

    assign instr_ready = state == S_RUN && !stall;
    assign accept      = instr_valid && instr_ready;
    assign halted      = state == S_HALT;
    // HALT itself reaching EX means everything older is retiring
    assign drained     = !id_valid && !(ex_valid && ex_op != OP_HALT);

    always_comb begin
        ex_res = '0;
        case (ex_op)
            6'd1, OP_ADDI: ex_res = ex_a + ex_b;
            6'd2:          ex_res = ex_a - ex_b;
            6'd3:          ex_res = ex_a & ex_b;
            6'd4:          ex_res = ex_a | ex_b;
            6'd5:          ex_res = ex_a ^ ex_b;
            6'd6:          ex_res = DATA_W'($signed(ex_a) < $signed(ex_b));
            6'd8:          ex_res = ex_a << ex_b[SW-1:0];
            default:       ex_res = '0;
        endcase
    end

    always_comb begin
        state_nx = (state == S_RUN && accept && instr[31:26] == OP_HALT) ? S_DRAIN :
                   (state == S_DRAIN && drained) ? S_HALT : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_RUN;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= PC_RESET;
            id_valid <= 1'b0;
            id_instr <= '0;
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else begin
            if (accept)
                pc <= pc + 32'd4;
            if (!stall) begin
                id_valid <= accept;
                if (accept)
                    id_instr <= instr;
            end
            ex_valid <= id_valid && !stall;
            ex_we    <= id_valid && !stall && id_we;
            ex_op    <= id_op;
            ex_rd    <= id_rd;
            ex_a     <= op_a;
            ex_b     <= (id_op == OP_ADDI) ? DATA_W'($signed(id_instr[15:0])) : op_b;
            wb_valid <= ex_we;
            if (ex_we) begin
                rf[ex_rd] <= ex_res;
                wb_addr   <= ex_rd;
                wb_data   <= ex_res;
            end
        end
    end
endmodule
